// File: rtl/trena_uc_n_if.sv
// trena_uc_n_if: sensor trigger and serial-TX character handshake of the trena control unit
interface trena_uc_n_if #(parameter int SEL_W = 2);
    logic medir;
    logic pronto_medida;
    logic partida_serial;
    logic pronto_serial;
    logic [SEL_W-1:0] sel_letra;
    modport master (output medir, partida_serial, sel_letra, input pronto_medida, pronto_serial);
    modport slave (input medir, partida_serial, sel_letra, output pronto_medida, pronto_serial);
endinterface

// File: rtl/trena_uc_n.sv
// trena_uc_n: trena control unit; single/periodic measurement with timeout, then per-character TX sequencing.
// Optional TRENA_UC_N_CANCELA_EN adds a cancela input that abandons the frame without issuing pronto.
module trena_uc_n #(
    parameter int N_CHARS = 4,
    parameter int SEL_W = 2,
    parameter int AUTO_PERIOD = 50000000,
    parameter int TIMEOUT = 5000000
) (
    input logic clock,
    input logic reset,
    input logic mensurar,
    input logic modo_auto,
`ifdef TRENA_UC_N_CANCELA_EN
    input logic cancela,
`endif
    trena_uc_n_if.master bus,
    output logic pronto,
    output logic erro_timeout,
    output logic [3:0] db_estado
);
    localparam int PW = $clog2(AUTO_PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CHARS - 1);
    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        MEDIR = 4'h1,
        AGUARDA_MEDIDA = 4'h2,
        TRANSMITE = 4'h3,
        ESPERA_SERIAL = 4'h4,
        PROXIMO = 4'h5,
        ESPERA_AUTO = 4'hA,
        ERRO = 4'hE,
        FINAL = 4'hF
    } state_t;
    state_t state, state_next;
    logic [PW-1:0] cnt_auto;
    logic [TW-1:0] cnt_timeout;
    logic [SEL_W-1:0] idx;
    logic cancel_now, cancel_serial;
    logic period_done, timeout_done;
    assign period_done = cnt_auto == PW'(AUTO_PERIOD - 1);
    assign timeout_done = cnt_timeout == TW'(TIMEOUT - 1);
`ifdef TRENA_UC_N_CANCELA_EN
    logic cancel_pend;
    // a cancel seen mid-character is held until that character finishes
    always_ff @(posedge clock)
        cancel_pend <= !reset && state_next == ESPERA_SERIAL && (cancel_pend || cancela);
    assign cancel_now = cancela;
    assign cancel_serial = cancela || cancel_pend;
`else
    assign cancel_now = 1'b0;
    assign cancel_serial = 1'b0;
`endif
    always_comb begin
        state_next = INICIAL;
        case (state)
            INICIAL: state_next = cancel_now ? INICIAL : modo_auto ? ESPERA_AUTO : mensurar ? MEDIR : INICIAL;
            ESPERA_AUTO: state_next = (cancel_now || !modo_auto) ? INICIAL : period_done ? MEDIR : ESPERA_AUTO;
            MEDIR: state_next = cancel_now ? INICIAL : AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: state_next = cancel_now ? INICIAL : pronto_medida_w() ? TRANSMITE : timeout_done ? ERRO : AGUARDA_MEDIDA;
            TRANSMITE: state_next = cancel_now ? INICIAL : ESPERA_SERIAL;
            ESPERA_SERIAL: state_next = !bus.pronto_serial ? ESPERA_SERIAL : cancel_serial ? INICIAL : idx == LAST ? FINAL : PROXIMO;
            PROXIMO: state_next = cancel_now ? INICIAL : TRANSMITE;
            FINAL, ERRO: state_next = (modo_auto && !cancel_now) ? ESPERA_AUTO : INICIAL;
            default: state_next = INICIAL;
        endcase
    end
    function automatic logic pronto_medida_w();
        return bus.pronto_medida;
    endfunction
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INICIAL;
            idx <= '0;
            cnt_auto <= '0;
            cnt_timeout <= '0;
            erro_timeout <= 1'b0;
        end else begin
            state <= state_next;
            idx <= state == MEDIR ? '0 : state == PROXIMO ? idx + 1'b1 : idx;
            cnt_auto <= state == ESPERA_AUTO ? cnt_auto + 1'b1 : '0;
            cnt_timeout <= state == AGUARDA_MEDIDA ? cnt_timeout + 1'b1 : '0;
            erro_timeout <= state_next == MEDIR ? 1'b0 : state_next == ERRO ? 1'b1 : erro_timeout;
        end
    end
    assign bus.medir = state == MEDIR;
    assign bus.partida_serial = state == TRANSMITE;
    assign bus.sel_letra = (state inside {TRANSMITE, ESPERA_SERIAL, PROXIMO}) ? idx : '0;
    assign pronto = state == FINAL;
    assign db_estado = state;
endmodule

// File: tb/tb_trena_uc_n.sv
// tb_trena_uc_n: directed table plus randomized frames; expected per-cycle outputs come from an event-timeline model.
module tb_trena_uc_n;
    localparam int NC = 4;
    localparam int SW = 2;
    localparam int AP = 20;
    localparam int TO = 16;
    typedef struct packed {
        logic rst, mens, am, pm, ps, can;
    } in_t;
    typedef struct packed {
        logic medir, partida;
        logic [SW-1:0] sel;
        logic pronto, err;
        logic [3:0] db;
    } out_t;
    typedef struct packed {
        in_t i;
        out_t o;
    } vec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mensurar = 1'b0;
    logic modo_auto = 1'b0;
`ifdef TRENA_UC_N_CANCELA_EN
    logic cancela = 1'b0;
`endif
    logic pronto, erro_timeout;
    logic [3:0] db_estado;
    trena_uc_n_if #(.SEL_W(SW)) bus();
    trena_uc_n #(.N_CHARS(NC), .SEL_W(SW), .AUTO_PERIOD(AP), .TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .mensurar(mensurar),
        .modo_auto(modo_auto),
`ifdef TRENA_UC_N_CANCELA_EN
        .cancela(cancela),
`endif
        .bus(bus),
        .pronto(pronto),
        .erro_timeout(erro_timeout),
        .db_estado(db_estado)
    );
    always #5 clock = ~clock;
    vec_t tab [10];
    vec_t v [4096];
    int c;
    int checks = 0;
    int errors = 0;
    int ds_a [NC];
    logic e_err = 1'b0;
    logic g_auto = 1'b0;
    logic g_noise = 1'b1;
    task automatic st(input logic [3:0] db, input int sel);
        v[c].i = '0;
        v[c].i.am = g_auto;
        if (g_noise) begin
            if (!(db inside {4'h0, 4'hA})) v[c].i.mens = 1'($urandom % 4 == 0);
            if (db != 4'h2) v[c].i.pm = 1'($urandom % 4 == 0);
            if (db != 4'h4) v[c].i.ps = 1'($urandom % 4 == 0);
        end
        v[c].o = '{medir: db == 4'h1, partida: db == 4'h3, sel: SW'(sel), pronto: db == 4'hF, err: e_err, db: db};
        c++;
    endtask
    task automatic start_single();
        st(4'h0, 0);
        v[c-1].i.mens = 1'b1;
    endtask
    task automatic espera();
        for (int j = 0; j < AP; j++) st(4'hA, 0);
    endtask
    task automatic start_auto();
        g_auto = 1'b1;
        st(4'h0, 0);
        v[c-1].i.mens = 1'($urandom % 2);
        espera();
    endtask
    task automatic frame(input int dm, input bit sp, input int ab, input int ak);
        e_err = 1'b0;
        st(4'h1, 0);
        if (dm < 0) begin
            for (int j = 0; j < TO; j++) st(4'h2, 0);
            e_err = 1'b1;
            st(4'hE, 0);
            return;
        end
        for (int j = 0; j <= dm; j++) st(4'h2, 0);
        v[c-1].i.pm = 1'b1;
        for (int i = 0; i < NC; i++) begin
            st(4'h3, i);
            if (sp) v[c-1].i.ps = 1'b1;
            for (int j = 0; j <= ds_a[i]; j++) begin
                st(4'h4, i);
                if (i == ab && j == 0 && ak == 2) begin
                    v[c-1].i.rst = 1'b1;
                    e_err = 1'b0;
                    return;
                end
                if (i == ab && j == 0) v[c-1].i.can = 1'b1;
                if (j == ds_a[i]) v[c-1].i.ps = 1'b1;
            end
            if (i == ab && ak == 1) return;
            if (i < NC - 1) begin
                st(4'h5, i);
                if (sp) v[c-1].i.ps = 1'b1;
            end else st(4'hF, 0);
        end
    endtask
    initial begin
        out_t act;
        int dm;
        tab = '{
            {6'b1_1_1_0_0_0, 10'b0_0_00_0_0_0000},
            {6'b0_0_0_1_1_0, 10'b0_0_00_0_0_0000},
            {6'b0_1_1_0_0_0, 10'b0_0_00_0_0_0000},
            {6'b0_0_0_0_0_0, 10'b0_0_00_0_0_1010},
            {6'b0_0_0_0_0_0, 10'b0_0_00_0_0_0000},
            {6'b0_1_0_0_0_0, 10'b0_0_00_0_0_0000},
            {6'b0_0_0_0_0_0, 10'b1_0_00_0_0_0001},
            {6'b0_0_0_0_0_0, 10'b0_0_00_0_0_0010},
            {6'b1_0_0_0_0_0, 10'b0_0_00_0_0_0010},
            {6'b0_0_0_0_0_0, 10'b0_0_00_0_0_0000}
        };
        for (int i = 0; i < 10; i++) v[i] = tab[i];
        c = 10;
        ds_a = '{4, 4, 4, 4};
        start_single();
        frame(7, 0, -1, 0);
        start_single();
        frame(-1, 0, -1, 0);
        start_single();
        frame(3, 0, -1, 0);
        start_single();
        frame(TO - 1, 1, -1, 0);
        ds_a = '{1, 1, 3, 1};
        start_single();
        frame(2, 0, 2, 2);
        start_single();
        frame(-1, 0, -1, 0);
        st(4'h0, 0);
        v[c-1].i.rst = 1'b1;
        e_err = 1'b0;
        start_auto();
        frame(5, 0, -1, 0);
        espera();
        g_auto = 1'b0;
        frame(4, 1, -1, 0);
`ifdef TRENA_UC_N_CANCELA_EN
        ds_a = '{1, 3, 1, 1};
        start_single();
        frame(2, 0, 1, 1);
`endif
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < NC; i++) ds_a[i] = int'($urandom_range(0, 5));
            dm = ($urandom % 4 == 0) ? -1 : ($urandom % 4 == 0) ? TO - 1 : int'($urandom_range(0, TO - 1));
            if ($urandom % 3 == 0) begin
                start_auto();
                g_auto = 1'b0;
            end else start_single();
            frame(dm, 1'($urandom % 2), -1, 0);
        end
        st(4'h0, 0);
        st(4'h0, 0);
        bus.pronto_medida = 1'b0;
        bus.pronto_serial = 1'b0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < c; i++) begin
            @(negedge clock);
            act = out_t'({bus.medir, bus.partida_serial, bus.sel_letra, pronto, erro_timeout, db_estado});
            checks++;
            if (act !== v[i].o) begin
                errors++;
                $display("FAIL step %0d {medir,partida,sel,pronto,err,db}: got %b expected %b", i, act, v[i].o);
            end
            if (i == 0 || v[i-1].i.rst) begin
                checks++;
                if (act !== '0) begin
                    errors++;
                    $display("FAIL step %0d reset state: got %b expected all zero", i, act);
                end
            end
            if (v[i].o.db == 4'hE) begin
                checks++;
                if (db_estado !== 4'hE || erro_timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL step %0d expired wait: db %h err %b expected db E err 1", i, db_estado, erro_timeout);
                end
            end
            reset = v[i].i.rst;
            mensurar = v[i].i.mens;
            modo_auto = v[i].i.am;
            bus.pronto_medida = v[i].i.pm;
            bus.pronto_serial = v[i].i.ps;
`ifdef TRENA_UC_N_CANCELA_EN
            cancela = v[i].i.can;
`endif
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
